// File: rtl/key_pkg.sv
// Shared encodings and 50 MHz board defaults for the push-button front end.
package key_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_PRESS_DEB   = 3'd1,
      ST_HELD_DELAY  = 3'd2,
      ST_HELD_REPEAT = 3'd3,
      ST_RELEASE_DEB = 3'd4
   } key_state_t;

   // Default timing for a 50 MHz clock: 1 ms debounce, 0.5 s first repeat, 0.1 s repeat rate.
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
   localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
   localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;
   localparam int unsigned DEF_CNT_W           = 25;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
//   clk   : destination clock
//   reset : synchronous, active-high; loads RESET_VAL into both flops
//   d     : asynchronous input
//   q     : synchronised output
module sync_2ff #(
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: synchronise, debounce, and generate press/release/step pulses
// with hold-to-auto-repeat.
//   clk           : system clock
//   reset         : synchronous, active-high
//   key_raw       : asynchronous button pin
//   key_level     : debounced pressed state (1 = pressed)
//   press_pulse   : one cycle per accepted press
//   release_pulse : one cycle per accepted release
//   step_pulse    : one cycle on press and on each auto-repeat tick
module key_conditioner
   import key_pkg::*;
#(
   parameter bit          KEY_ACTIVE_LOW  = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter bit          REPEAT_EN       = 1'b1,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic step_pulse
);

   localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic             key_sync;
   logic             pressed;
   key_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             level_n, press_n, release_n, step_n;

   // Synchroniser resets to the released pin level so reset never looks like a press.
   sync_2ff #(.RESET_VAL(KEY_ACTIVE_LOW)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (key_raw),
      .q     (key_sync)
   );

   assign pressed = key_sync ^ KEY_ACTIVE_LOW;

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         key_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         step_pulse    <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         key_level     <= level_n;
         press_pulse   <= press_n;
         release_pulse <= release_n;
         step_pulse    <= step_n;
      end
   end

   // Next state / next outputs; every state entry clears the counter.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt + CNT_W'(1);
      level_n   = key_level;
      press_n   = 1'b0;
      release_n = 1'b0;
      step_n    = 1'b0;

      case (state)
         ST_IDLE: begin
            level_n = 1'b0;
            cnt_n   = '0;
            if (pressed) state_n = ST_PRESS_DEB;
         end

         ST_PRESS_DEB: begin
            if (!pressed) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else if (cnt == DEB_LAST) begin
               state_n = ST_HELD_DELAY;
               cnt_n   = '0;
               press_n = 1'b1;
               step_n  = 1'b1;
               level_n = 1'b1;
            end
         end

         ST_HELD_DELAY: begin
            if (!pressed) begin
               state_n = ST_RELEASE_DEB;
               cnt_n   = '0;
            end else if (!REPEAT_EN) begin
               cnt_n = '0;
            end else if (cnt == DELAY_LAST) begin
               state_n = ST_HELD_REPEAT;
               cnt_n   = '0;
               step_n  = 1'b1;
            end
         end

         ST_HELD_REPEAT: begin
            if (!pressed) begin
               state_n = ST_RELEASE_DEB;
               cnt_n   = '0;
            end else if (cnt == PERIOD_LAST) begin
               cnt_n  = '0;
               step_n = 1'b1;
            end
         end

         ST_RELEASE_DEB: begin
            level_n = 1'b1;
            if (pressed) begin
               // Release bounce: back to held with a fresh repeat delay.
               state_n = ST_HELD_DELAY;
               cnt_n   = '0;
            end else if (cnt == DEB_LAST) begin
               state_n   = ST_IDLE;
               cnt_n     = '0;
               release_n = 1'b1;
               level_n   = 1'b0;
            end
         end

         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            level_n = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Front-end stage for one push-button (DE-board KEY, active-low by default).
- Synchronises the raw pin to clk and debounces it with a digital counter.
- Produces a clean level, one-cycle press/release pulses, and a step pulse with hold-to-auto-repeat.
- Feeds the downstream hex up/down counter/7-segment stage: one instance per button, step_pulse drives increment_button or decrement_button.

Parameters:
- KEY_ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = reads 1 when pressed.
- DEBOUNCE_CYCLES, 50000, cycles the synchronised input must stay stable to accept a press or release (1 ms @ 50 MHz); >= 1.
- REPEAT_EN, 1, 1 = auto-repeat on hold; 0 = step_pulse only on press.
- REPEAT_DELAY, 25000000, cycles from accepted press to first repeat step (0.5 s); >= 1.
- REPEAT_PERIOD, 5000000, cycles between later repeat steps (0.1 s); >= 1.
- CNT_W, 25, shared counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) - 1.

Ports:
- clk, input, 1: system clock, all logic on rising edge.
- reset, input, 1: synchronous, active-high; clears all state.
- key_raw, input, 1: asynchronous raw button pin.
- key_level, output, 1: debounced pressed state, 1 = pressed.
- press_pulse, output, 1: one-cycle pulse on each accepted press.
- release_pulse, output, 1: one-cycle pulse on each accepted release.
- step_pulse, output, 1: one-cycle pulse on press and on each auto-repeat tick.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, synchroniser flops = released level. Reset has priority over every other event.
- Synchroniser: 2 flops. pressed = sync2 XOR KEY_ACTIVE_LOW.
- All outputs are registered. Pulses last exactly 1 cycle; no two pulses of the same output are adjacent except via reset.
- Single counter cnt, cleared on every state entry. "Expire" means cnt == N-1 at a clock edge; otherwise cnt increments.

State machine:
- IDLE: key_level = 0. If pressed, go to PRESS_DEB.
- PRESS_DEB:
  - pressed drops: back to IDLE, no pulse (bounce).
  - DEBOUNCE_CYCLES expires: go to HELD_DELAY; press_pulse = step_pulse = 1; key_level <= 1.
- HELD_DELAY:
  - pressed drops: go to RELEASE_DEB.
  - REPEAT_EN = 1 and REPEAT_DELAY expires: go to HELD_REPEAT, step_pulse = 1.
  - REPEAT_EN = 0: cnt holds at 0 and the state never advances.
- HELD_REPEAT:
  - pressed drops: go to RELEASE_DEB.
  - REPEAT_PERIOD expires: step_pulse = 1, cnt <= 0, stay.
- RELEASE_DEB: key_level stays 1.
  - pressed returns: go to HELD_DELAY, no pulse; the repeat delay restarts.
  - DEBOUNCE_CYCLES expires: go to IDLE; release_pulse = 1; key_level <= 0.

Latency:
- Edge 1 = first edge that samples key_raw at the pressed level, held stable.
- press_pulse is high in the cycle after edge DEBOUNCE_CYCLES+3.
- Release timing is symmetric.

Boundaries:
- Bounce shorter than DEBOUNCE_CYCLES produces no pulse and no level change.
- Reset while held returns to IDLE. If the key is still pressed after reset, it is re-debounced and produces a fresh press_pulse.
- cnt never wraps; CNT_W is too small means misconfiguration, and the bench asserts on it.

Decomposition:
- Package key_pkg holds:
  - state encoding localparams: ST_IDLE, ST_PRESS_DEB, ST_HELD_DELAY, ST_HELD_REPEAT, ST_RELEASE_DEB (3-bit);
  - default timing constants for the 50 MHz board clock.
- One sub-module, sync_2ff: 2-flop synchroniser, parameterised reset value, synchronous active-high reset. Reused for other asynchronous board inputs.
- FSM and counter stay in key_conditioner.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, KEY_ACTIVE_LOW=1; edge 1 = first edge sampling key_raw=0):
1. Reset for 3 cycles with key_raw=1 -> all outputs 0; no pulse after reset deasserts.
2. key_raw=0 held 12 cycles -> press_pulse and step_pulse high only after edge 7; key_level=1 from edge 7.
3. key_raw=0 for 3 cycles, then 1 -> no pulses; key_level stays 0.
4. key_raw=0 held 30 cycles -> step_pulse after edges 7, 17, 20, 23, 26, 29 (6 steps); press_pulse only once.
5. Release after scenario 2:
   - key_raw=1 with a 2-cycle glitch back to 0 mid-debounce -> no release pulse;
   - then stable 1 -> release_pulse one cycle, key_level=0 same edge.
6. Reset asserted during HELD_REPEAT with key still 0, deasserted after 2 cycles -> outputs 0 next edge; fresh press_pulse DEBOUNCE_CYCLES+3 edges after deassertion.
